// File: rtl/objsched_pkg.sv
// ---------------------------------------------------------------------------
// objsched_pkg
// Shared definitions for the object line-buffer sequencer:
//   - sched_state_t : sequencer states (IDLE, FETCH, DRAIN, DONE)
//   - F_*           : object RAM field selectors (low two bits of or_addr)
//   - PH_*          : fetch phase on which each field is latched from od
//   - field_of()    : maps a fetch phase to the field presented on or_addr
// ---------------------------------------------------------------------------
package objsched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam logic [1:0] F_CODE = 2'd0;
  localparam logic [1:0] F_ATTR = 2'd1;
  localparam logic [1:0] F_Y    = 2'd2;
  localparam logic [1:0] F_X    = 2'd3;

  localparam logic [2:0] PH_CODE = 3'd1;
  localparam logic [2:0] PH_ATTR = 3'd3;
  localparam logic [2:0] PH_Y    = 3'd5;
  localparam logic [2:0] PH_X    = 3'd7;

  // Each field is addressed for two pix_ce ticks; od is latched on the second.
  function automatic logic [1:0] field_of(input logic [2:0] phase);
    return phase[2:1];
  endfunction

endpackage

// File: rtl/obj_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// obj_wr_addr_gen
// Draw stage of the object sequencer. Holds the X position and in-range flag
// of the object handed over by the fetch stage and produces the draw-buffer
// write address/strobe for the eight pixels of that object.
// Ports:
//   clkm_48MHZ, reset : clock, synchronous active-high reset
//   pix_ce            : pixel enable; writes happen only on these ticks
//   load              : capture x_in / in_range_in (end of a slot fetch)
//   drain_end         : last drain tick; the held object is retired after it
//   abort             : line_start; drops the held object immediately
//   x_in, in_range_in : object X and "draw this object" flag
//   phase             : pixel index 0..7 within the object
//   obj_en, hinv      : layer enable, horizontal flip of the address
//   wr_addr, wr_en    : draw-buffer address and one-cycle write strobe
// ---------------------------------------------------------------------------
module obj_wr_addr_gen (
  input  logic       clkm_48MHZ,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       load,
  input  logic       drain_end,
  input  logic       abort,
  input  logic [7:0] x_in,
  input  logic       in_range_in,
  input  logic [2:0] phase,
  input  logic       obj_en,
  input  logic       hinv,
  output logic [7:0] wr_addr,
  output logic       wr_en
);

  logic       active_reg;
  logic       in_range_reg;
  logic [7:0] x_reg;
  logic       drawing;
  logic [7:0] addr_sum;

  always_ff @(posedge clkm_48MHZ) begin
    if (reset || abort) begin
      active_reg   <= 1'b0;
      in_range_reg <= 1'b0;
      x_reg        <= 8'd0;
    end else if (load) begin
      active_reg   <= 1'b1;
      in_range_reg <= in_range_in;
      x_reg        <= x_in;
    end else if (drain_end) begin
      active_reg   <= 1'b0;
      in_range_reg <= 1'b0;
      x_reg        <= 8'd0;
    end
  end

  assign drawing  = active_reg && in_range_reg;
  assign addr_sum = x_reg + {5'd0, phase};
  // A line_start tick never writes: the buffers swap on that very edge.
  assign wr_en    = pix_ce && !abort && drawing && obj_en;

  // Flip is a bitwise inversion of the wrapped address.
  for (genvar gi = 0; gi < 8; gi++) begin : g_addr_bit
    assign wr_addr[gi] = drawing && (addr_sum[gi] ^ hinv);
  end

endmodule

// File: rtl/obj_line_sched.sv
// ---------------------------------------------------------------------------
// obj_line_sched
// Per-line sequencer for the object double line buffer. Each line it walks
// the object RAM (code, attr, Y, X per slot over eight pix_ce ticks), range
// checks each object against the next line and drives the draw-buffer writes
// one slot behind the fetch. In parallel it reads out and clears the display
// buffer. Buffer roles swap on every line_start.
// Optional feature: define OBJ_LIMIT_EN to cap drawn objects per line at
// MAX_PER_LINE and raise ovf when later in-range objects are dropped.
// Ports:
//   clkm_48MHZ, reset      : clock, synchronous active-high reset
//   pix_ce                 : pixel enable (one clock wide)
//   line_start             : starts a new line (restarts from any state)
//   rd_active              : visible readout window
//   vpos                   : current scan line
//   obj_en, hinv           : layer enable, horizontal flip
//   od                     : object RAM read data
//   or_addr                : object RAM address {slot, field}
//   obj_code/attr/row      : object currently being drawn
//   lnsel                  : draw-buffer select (display buffer is !lnsel)
//   wr_addr, wr_en         : draw-buffer write
//   rd_addr                : display-buffer read address
//   clr_addr, clr_en       : display-buffer clear (one pix_ce behind read)
//   busy                   : FETCH or DRAIN in progress
//   ovf                    : per-line object limit overflow
// ---------------------------------------------------------------------------
module obj_line_sched
  import objsched_pkg::*;
#(
  parameter int NUM_SLOTS    = 32,
  parameter int SLOT_W       = 5,
  parameter int MAX_PER_LINE = 16
) (
  input  logic              clkm_48MHZ,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              line_start,
  input  logic              rd_active,
  input  logic [7:0]        vpos,
  input  logic              obj_en,
  input  logic              hinv,
  input  logic [7:0]        od,
  output logic [SLOT_W+1:0] or_addr,
  output logic [7:0]        obj_code,
  output logic [7:0]        obj_attr,
  output logic [3:0]        obj_row,
  output logic              lnsel,
  output logic [7:0]        wr_addr,
  output logic              wr_en,
  output logic [7:0]        rd_addr,
  output logic              clr_en,
  output logic [7:0]        clr_addr,
  output logic              busy,
  output logic              ovf
);

  if ((1 << SLOT_W) != NUM_SLOTS || MAX_PER_LINE < 1) begin : g_bad_params
    $error("obj_line_sched: NUM_SLOTS must be 2**SLOT_W and MAX_PER_LINE positive");
  end
  if (field_of(PH_CODE) != F_CODE || field_of(PH_ATTR) != F_ATTR ||
      field_of(PH_Y) != F_Y || field_of(PH_X) != F_X) begin : g_bad_schedule
    $error("obj_line_sched: latch phases do not line up with RAM fields");
  end

  sched_state_t      state_reg;
  logic [2:0]        phase_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic              lnsel_reg;
  // fetch stage
  logic [7:0]        code_reg;
  logic [7:0]        attr_reg;
  logic [3:0]        row_reg;
  logic              in_range_reg;
  // draw stage (X / in_range live in the address generator)
  logic [7:0]        draw_code_reg;
  logic [7:0]        draw_attr_reg;
  logic [3:0]        draw_row_reg;
  // readout
  logic [7:0]        rd_addr_reg;
  logic [7:0]        clr_addr_reg;
  logic              clr_pend_reg;

  logic              fetch_tick;
  logic              handoff;
  logic              drain_end;
  logic              draw_in_range;
  logic [7:0]        y_sum;

  assign fetch_tick = pix_ce && !line_start && (state_reg == FETCH);
  assign handoff    = fetch_tick && (phase_reg == PH_X);
  assign drain_end  = pix_ce && !line_start && (state_reg == DRAIN) && (phase_reg == 3'd7);
  // Objects are checked against the line being prepared, hence the +1.
  assign y_sum      = od + vpos + 8'd1;

`ifdef OBJ_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  logic [CNT_W-1:0] obj_cnt_reg;
  logic             ovf_reg;
  logic             limit_hit;

  assign limit_hit = (obj_cnt_reg >= CNT_W'(MAX_PER_LINE));

  // Counts at hand-over time, so the count only includes objects whose
  // fetch has completed on this line.
  always_ff @(posedge clkm_48MHZ) begin
    if (reset || line_start) begin
      obj_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
    end else if (handoff && in_range_reg) begin
      if (limit_hit) begin
        ovf_reg <= 1'b1;
      end else begin
        obj_cnt_reg <= obj_cnt_reg + 1'b1;
      end
    end
  end

  assign draw_in_range = in_range_reg && !limit_hit;
  assign ovf           = ovf_reg;
`else
  assign draw_in_range = in_range_reg;
  assign ovf           = 1'b0;
`endif

  always_ff @(posedge clkm_48MHZ) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_reg     <= 3'd0;
      slot_reg      <= '0;
      lnsel_reg     <= 1'b0;
      code_reg      <= 8'd0;
      attr_reg      <= 8'd0;
      row_reg       <= 4'd0;
      in_range_reg  <= 1'b0;
      draw_code_reg <= 8'd0;
      draw_attr_reg <= 8'd0;
      draw_row_reg  <= 4'd0;
      rd_addr_reg   <= 8'd0;
      clr_addr_reg  <= 8'd0;
      clr_pend_reg  <= 1'b0;
    end else if (line_start) begin
      // Restart from any state; whatever the old line was drawing is dropped.
      lnsel_reg     <= ~lnsel_reg;
      state_reg     <= FETCH;
      phase_reg     <= 3'd0;
      slot_reg      <= '0;
      draw_code_reg <= 8'd0;
      draw_attr_reg <= 8'd0;
      draw_row_reg  <= 4'd0;
      rd_addr_reg   <= 8'd0;
      clr_pend_reg  <= 1'b0;
    end else if (pix_ce) begin
      case (state_reg)
        FETCH: begin
          phase_reg <= phase_reg + 3'd1;
          case (phase_reg)
            PH_CODE: code_reg <= od;
            PH_ATTR: attr_reg <= od;
            PH_Y: begin
              row_reg      <= y_sum[3:0];
              in_range_reg <= &y_sum[7:4];
            end
            PH_X: begin
              draw_code_reg <= code_reg;
              draw_attr_reg <= attr_reg;
              draw_row_reg  <= row_reg;
              slot_reg      <= slot_reg + 1'b1;
              if (slot_reg == SLOT_W'(NUM_SLOTS - 1)) begin
                state_reg <= DRAIN;
              end
            end
            default: ;
          endcase
        end
        DRAIN: begin
          phase_reg <= phase_reg + 3'd1;
          if (phase_reg == 3'd7) begin
            state_reg     <= DONE;
            draw_code_reg <= 8'd0;
            draw_attr_reg <= 8'd0;
            draw_row_reg  <= 4'd0;
          end
        end
        default: ;
      endcase

      if (rd_active) begin
        rd_addr_reg <= rd_addr_reg + 8'd1;
      end
      clr_addr_reg <= rd_addr_reg;
      clr_pend_reg <= rd_active;
    end
  end

  obj_wr_addr_gen u_wr_addr_gen (
    .clkm_48MHZ  (clkm_48MHZ),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .load        (handoff),
    .drain_end   (drain_end),
    .abort       (line_start),
    .x_in        (od),
    .in_range_in (draw_in_range),
    .phase       (phase_reg),
    .obj_en      (obj_en),
    .hinv        (hinv),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en)
  );

  assign or_addr  = (state_reg == FETCH) ? {slot_reg, field_of(phase_reg)} : '0;
  assign obj_code = draw_code_reg;
  assign obj_attr = draw_attr_reg;
  assign obj_row  = draw_row_reg;
  assign lnsel    = lnsel_reg;
  assign rd_addr  = rd_addr_reg;
  assign clr_addr = clr_addr_reg;
  // Suppressed on line_start: the buffer it would clear has just become the draw buffer.
  assign clr_en   = pix_ce && !line_start && clr_pend_reg;
  assign busy     = (state_reg == FETCH) || (state_reg == DRAIN);

endmodule

// File: tb/tb_obj_line_sched.sv
// ---------------------------------------------------------------------------
// tb_obj_line_sched
// Self-checking bench for obj_line_sched. A reference model computes, from
// the object RAM contents, the full list of expected draw-buffer writes for a
// line (tick, address, code, attr, row) and the readout/clear sequence; the
// DUT's strobes are captured per pix_ce tick and compared. Prints one line
// per scan line. Honours OBJ_LIMIT_EN like the design.
// ---------------------------------------------------------------------------
module tb_obj_line_sched;

  localparam int NUM_SLOTS    = 32;
  localparam int SLOT_W       = 5;
  localparam int MAX_PER_LINE = 16;
  localparam int FULL_TICKS   = NUM_SLOTS * 8 + 8;
`ifdef OBJ_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic              clkm_48MHZ = 1'b0;
  logic              reset;
  logic              pix_ce;
  logic              line_start;
  logic              rd_active;
  logic [7:0]        vpos;
  logic              obj_en;
  logic              hinv;
  logic [7:0]        od = 8'd0;
  logic [SLOT_W+1:0] or_addr;
  logic [7:0]        obj_code;
  logic [7:0]        obj_attr;
  logic [3:0]        obj_row;
  logic              lnsel;
  logic [7:0]        wr_addr;
  logic              wr_en;
  logic [7:0]        rd_addr;
  logic              clr_en;
  logic [7:0]        clr_addr;
  logic              busy;
  logic              ovf;

  obj_line_sched #(
    .NUM_SLOTS    (NUM_SLOTS),
    .SLOT_W       (SLOT_W),
    .MAX_PER_LINE (MAX_PER_LINE)
  ) dut (
    .clkm_48MHZ (clkm_48MHZ),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .rd_active  (rd_active),
    .vpos       (vpos),
    .obj_en     (obj_en),
    .hinv       (hinv),
    .od         (od),
    .or_addr    (or_addr),
    .obj_code   (obj_code),
    .obj_attr   (obj_attr),
    .obj_row    (obj_row),
    .lnsel      (lnsel),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .rd_addr    (rd_addr),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clkm_48MHZ = ~clkm_48MHZ;

  // Object RAM: data for the address seen on one pix_ce tick is on od by the next.
  logic [7:0] obj_mem [0:NUM_SLOTS*4-1];
  always @(posedge clkm_48MHZ) if (pix_ce) od <= obj_mem[or_addr];

  typedef struct {
    int         t;
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] at;
    logic [3:0] r;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_idx = 0;
  bit   rd_chk   = 1'b0;
  int   exp_rd   = 0;
  int   prev_rd  = 0;
  bit   prev_act = 1'b0;
  logic exp_lnsel = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pix_ce period: a low clock, then a clock with pix_ce high. Strobes are
  // sampled just after the falling edge, before the active edge of that tick.
  task automatic pix_tick(input logic ls, input logic act);
    @(negedge clkm_48MHZ);
    pix_ce = 1'b0; line_start = 1'b0;
    #1;
    check_val("no_strobe_without_ce", {30'd0, wr_en, clr_en}, 32'd0);
    @(negedge clkm_48MHZ);
    pix_ce = 1'b1; line_start = ls; rd_active = act;
    #1;
    if (ls) begin
      check_val("wr_en_on_line_start", wr_en, 1'b0);
      check_val("clr_en_on_line_start", clr_en, 1'b0);
      exp_rd = 0; prev_act = 1'b0; tick_idx = 0;
    end else begin
      if (wr_en) got_q.push_back('{tick_idx, wr_addr, obj_code, obj_attr, obj_row});
      if (rd_chk) begin
        check_val("rd_addr", rd_addr, exp_rd);
        check_val("clr_en", clr_en, prev_act);
        if (prev_act) check_val("clr_addr", clr_addr, prev_rd);
      end
      if (act) begin
        prev_rd = exp_rd;
        exp_rd  = (exp_rd + 1) % 256;
      end
      prev_act = act;
      tick_idx++;
    end
  endtask

  task automatic set_slot(input int s, input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] y, input logic [7:0] x);
    obj_mem[s*4+0] = c;
    obj_mem[s*4+1] = a;
    obj_mem[s*4+2] = y;
    obj_mem[s*4+3] = x;
  endtask

  // Fill all slots; roughly pct_in percent of them land on the next line.
  task automatic fill_mem(input int pct_in);
    logic [7:0] y;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if ($urandom_range(99) < pct_in) y = 8'hF0 + 8'($urandom_range(15)) - vpos - 8'd1;
      else y = 8'($urandom);
      set_slot(s, 8'($urandom), 8'($urandom), y, 8'($urandom));
    end
  endtask

  // Every slot out of range (Y + vpos + 1 == 0x20).
  task automatic fill_out_of_range();
    for (int s = 0; s < NUM_SLOTS; s++)
      set_slot(s, 8'($urandom), 8'($urandom), 8'h20 - vpos - 8'd1, 8'($urandom));
  endtask

  // One scan line: line_start, then n_ticks pix_ce ticks, the first rd_ticks
  // with rd_active. Slot s is fetched on ticks 8s..8s+7 and drawn on ticks
  // 8(s+1)..8(s+1)+7.
  task automatic run_line(input string name, input int n_ticks, input int rd_ticks);
    logic [7:0] y, sum, base;
    int  cnt;
    bit  exp_ovf;
    wr_t w;
    int  nmin;
    exp_q.delete();
    got_q.delete();
    cnt = 0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (8 * s + 7 >= n_ticks) break;
      y   = obj_mem[s*4+2];
      sum = y + vpos + 8'd1;
      if (sum[7:4] == 4'hF) begin
        cnt++;
        if (obj_en && (!LIMIT_ON || cnt <= MAX_PER_LINE)) begin
          for (int p = 0; p < 8; p++) begin
            if (8 * (s + 1) + p < n_ticks) begin
              base = obj_mem[s*4+3] + 8'(p);
              w.t  = 8 * (s + 1) + p;
              w.a  = hinv ? ~base : base;
              w.c  = obj_mem[s*4+0];
              w.at = obj_mem[s*4+1];
              w.r  = sum[3:0];
              exp_q.push_back(w);
            end
          end
        end
      end
    end
    exp_ovf = LIMIT_ON && (cnt > MAX_PER_LINE);

    exp_lnsel = ~exp_lnsel;
    pix_tick(1'b1, 1'b0);
    @(posedge clkm_48MHZ);
    #1;
    check_val({name, " lnsel"}, lnsel, exp_lnsel);
    check_val({name, " ovf_cleared"}, ovf, 1'b0);
    check_val({name, " busy_start"}, busy, 1'b1);
    check_val({name, " rd_addr_start"}, rd_addr, 8'd0);

    rd_chk = 1'b1;
    for (int i = 0; i < n_ticks; i++) pix_tick(1'b0, i < rd_ticks);
    rd_chk = 1'b0;
    @(negedge clkm_48MHZ);
    pix_ce = 1'b0; rd_active = 1'b0;
    #1;
    check_val({name, " busy_end"}, busy, n_ticks < FULL_TICKS);
    check_val({name, " ovf"}, ovf, exp_ovf);
    check_val({name, " rd_addr_end"}, rd_addr, rd_ticks % 256);

    check_val({name, " n_writes"}, got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check_val({name, " wr_tick"}, got_q[i].t, exp_q[i].t);
      check_val({name, " wr_addr"}, got_q[i].a, exp_q[i].a);
      check_val({name, " obj_code"}, got_q[i].c, exp_q[i].c);
      check_val({name, " obj_attr"}, got_q[i].at, exp_q[i].at);
      check_val({name, " obj_row"}, got_q[i].r, exp_q[i].r);
    end
    $display("line %s: vpos=%02h hinv=%0d obj_en=%0d ticks=%0d writes=%0d expected=%0d ovf=%0d errors=%0d",
             name, vpos, hinv, obj_en, n_ticks, got_q.size(), exp_q.size(), ovf, n_errors);
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, " or_addr"}, or_addr, 0);
    check_val({name, " obj_code"}, obj_code, 0);
    check_val({name, " obj_attr"}, obj_attr, 0);
    check_val({name, " obj_row"}, obj_row, 0);
    check_val({name, " lnsel"}, lnsel, 0);
    check_val({name, " wr_addr"}, wr_addr, 0);
    check_val({name, " wr_en"}, wr_en, 0);
    check_val({name, " rd_addr"}, rd_addr, 0);
    check_val({name, " clr_en"}, clr_en, 0);
    check_val({name, " clr_addr"}, clr_addr, 0);
    check_val({name, " busy"}, busy, 0);
    check_val({name, " ovf"}, ovf, 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pix_ce = 1'b0; line_start = 1'b0; rd_active = 1'b0;
    vpos = 8'h10; obj_en = 1'b1; hinv = 1'b0;
    for (int i = 0; i < NUM_SLOTS * 4; i++) obj_mem[i] = 8'd0;
    repeat (4) @(negedge clkm_48MHZ);
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    // Reset in the middle of FETCH (slot 5, phase 3).
    fill_mem(50);
    run_line("pre_reset", 43, 10);
    @(negedge clkm_48MHZ); reset = 1'b1;
    @(negedge clkm_48MHZ); reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_lnsel = 1'b0;
    got_q.delete();
    repeat (20) pix_tick(1'b0, 1'b0);
    check_val("idle_no_writes", got_q.size(), 0);
    check_val("idle_busy", busy, 1'b0);
    $display("line idle_after_reset: writes=%0d busy=%0d errors=%0d", got_q.size(), busy, n_errors);

    // Directed: Y=0xEF with vpos 0x10 is just off the next line.
    vpos = 8'h10; hinv = 1'b0; obj_en = 1'b1;
    fill_out_of_range();
    set_slot(0, 8'h11, 8'h22, 8'hEF, 8'h40);
    run_line("y_ef", FULL_TICKS, 0);
    check_val("y_ef no_writes", got_q.size(), 0);

    set_slot(0, 8'h11, 8'h22, 8'hE0, 8'h40);
    run_line("y_e0", FULL_TICKS, 0);
    if (got_q.size() == 8) begin
      check_val("y_e0 first", got_q[0].a, 8'h40);
      check_val("y_e0 last", got_q[7].a, 8'h47);
      check_val("y_e0 row", got_q[0].r, 4'd1);
      check_val("y_e0 tick", got_q[0].t, 8);
    end

    hinv = 1'b1;
    run_line("hinv", FULL_TICKS, 0);
    if (got_q.size() == 8) begin
      check_val("hinv first", got_q[0].a, 8'hBF);
      check_val("hinv last", got_q[7].a, 8'hB8);
    end

    hinv = 1'b0;
    set_slot(0, 8'h11, 8'h22, 8'hE0, 8'hFC);
    run_line("x_wrap", FULL_TICKS, 0);
    if (got_q.size() == 8) begin
      check_val("x_wrap ff", got_q[3].a, 8'hFF);
      check_val("x_wrap 00", got_q[4].a, 8'h00);
      check_val("x_wrap 03", got_q[7].a, 8'h03);
    end

    // Readout over 300 ticks wraps rd_addr to 44.
    fill_mem(50);
    run_line("readout", 300, 300);
    check_val("readout wrap", rd_addr, 8'd44);

    // Layer disabled: no writes, readout/clear unaffected.
    obj_en = 1'b0;
    fill_mem(100);
    run_line("obj_off", FULL_TICKS + 8, 100);
    check_val("obj_off no_writes", got_q.size(), 0);
    obj_en = 1'b1;

    // 20 in-range objects: limited to MAX_PER_LINE when the limit is built in.
    fill_out_of_range();
    for (int s = 0; s < 20; s++) set_slot(s, 8'($urandom), 8'($urandom), 8'hE3, 8'($urandom));
    run_line("limit", FULL_TICKS, 0);
    check_val("limit writes", got_q.size(), LIMIT_ON ? 128 : 160);
    check_val("limit ovf", ovf, LIMIT_ON);

    // Truncated line followed by a full one.
    fill_mem(60);
    run_line("trunc", 100, 50);
    run_line("after_trunc", FULL_TICKS, 0);

    for (int k = 0; k < 8; k++) begin
      int n;
      vpos   = 8'($urandom);
      hinv   = 1'($urandom);
      obj_en = ($urandom_range(3) != 0);
      fill_mem(40);
      n = FULL_TICKS + $urandom_range(8);
      run_line($sformatf("rand%0d", k), n, $urandom_range(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obj_line_sched.md
Name: obj_line_sched

Overview:
- Sequencer for the sprite (object) double line buffer in the object bus.
- Each scan line it walks the object RAM slots and fetches code, attribute, Y and X for each slot.
- It range-checks each object against the next line and drives write addresses into the "draw" buffer.
- At the same time it reads out and clears the "display" buffer. Buffer roles swap on every line start.
- Replaces ripple-clocked phase strobes with a single-clock, clock-enable design.

Parameters:
- NUM_SLOTS, 32, object slots scanned per line (power of 2, 8..64).
- SLOT_W, 5, log2(NUM_SLOTS).
- MAX_PER_LINE, 16, drawn-object limit; used only with OBJ_LIMIT_EN.

Ports:
- clkm_48MHZ  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- pix_ce  in  1  6 MHz pixel enable, one clkm_48MHZ cycle wide.
- line_start  in  1  pulse, aligned to pix_ce; starts a new line.
- rd_active  in  1  high during the visible readout window.
- vpos  in  8  current scan line.
- obj_en  in  1  object layer enable (OBJOFF equivalent).
- hinv  in  1  horizontal flip of the write address.
- od  in  8  object RAM read data, valid on the pix_ce tick after or_addr changes.
- or_addr  out  SLOT_W+2  object RAM address: {slot, field}; field 0=code, 1=attr, 2=Y, 3=X.
- obj_code  out  8  latched code of the object being drawn.
- obj_attr  out  8  latched attribute of the object being drawn.
- obj_row  out  4  sprite row for the object being drawn.
- lnsel  out  1  draw-buffer select; display buffer is !lnsel.
- wr_addr  out  8  draw-buffer address.
- wr_en  out  1  draw-buffer write strobe (one clkm_48MHZ cycle, coincident with pix_ce).
- rd_addr  out  8  display-buffer read address.
- clr_en  out  1  write-zero strobe to the display buffer at clr_addr.
- clr_addr  out  8  rd_addr delayed by one pix_ce.
- busy  out  1  high while in FETCH or DRAIN.
- ovf  out  1  per-line overflow flag (OBJ_LIMIT_EN only; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; lnsel=0; state IDLE; phase=0; slot=0.
- Everything advances only on pix_ce, except reset and the line_start restart.
- States:
  - IDLE: wait for line_start.
  - FETCH: 8-phase slot cycle.
  - DRAIN: draw the last slot.
  - DONE: wait for next line_start.
- line_start, in any state:
  - toggle lnsel; slot=0; phase=0; rd_addr=0; ovf=0; go to FETCH;
  - discard the pending draw from the previous line (a line_start mid-line aborts it cleanly).
- FETCH phase schedule (phase 0..7 counts pix_ce ticks):
  - or_addr field = phase[2:1].
  - phase 1: latch code.
  - phase 3: latch attr.
  - phase 5: sum = od + vpos + 1, mod 256. in_range = (sum[7:4]==4'hF); row = sum[3:0].
  - phase 7: latch X; hand {code, attr, row, X, in_range} to the draw stage; slot++.
  - After slot NUM_SLOTS-1, phase 7: go to DRAIN.
- Draw stage (pipelined one slot behind fetch):
  - On phases 0..7, if in_range && obj_en: wr_en=1, wr_addr = X+phase (mod 256), or ~(X+phase) when hinv=1.
  - Out-of-range slot: no writes; the slot time is still consumed.
- DRAIN: 8 pix_ce ticks completing the last slot's draw, then DONE. DONE holds outputs at 0 except lnsel.
- Readout:
  - While rd_active, each pix_ce: rd_addr++ (wraps 255->0).
  - clr_en pulses one pix_ce later at clr_addr.
  - Readout and clear proceed regardless of obj_en.
- Latency: od sampled at phase 5 affects wr_en from the next slot's phase 0, i.e. 3 pix_ce later.
- A line with NUM_SLOTS*8 + 8 pix_ce ticks or more completes fully. A shorter line is truncated by line_start.

Optional Feature:
- OBJ_LIMIT_EN defined:
  - count in-range objects per line;
  - once the count reaches MAX_PER_LINE, later in-range objects are not drawn and ovf=1 until the next line_start.
- OBJ_LIMIT_EN undefined: no limit; ovf tied 0.

Decomposition:
- Package objsched_pkg: state enum (IDLE, FETCH, DRAIN, DONE); field constants F_CODE=0, F_ATTR=1, F_Y=2, F_X=3; phase constants PH_CODE=1, PH_ATTR=3, PH_Y=5, PH_X=7.
- One sub-module, obj_wr_addr_gen: holds the draw-stage X, in_range and hinv handling, and outputs wr_addr/wr_en.

Test Plan:
- Reset mid-FETCH (slot 5, phase 3) -> next cycle all outputs 0, lnsel=0, state IDLE; no wr_en until line_start.
- vpos=0x10, slot0 Y=0xEF (sum=0x00) -> not in range, no wr_en. Y=0xE0 (sum=0xF1) -> in range, row=1. X=0x40 -> wr_addr 0x40..0x47 in slot1's phases 0..7.
- Same object with hinv=1 -> wr_addr 0xBF..0xB8. X=0xFC, hinv=0 -> addresses 0xFC..0xFF then 0x00..0x03.
- Two line_starts -> lnsel toggles 0->1->0. 300 pix_ce with rd_active=1 -> rd_addr wraps to 44; clr_en trails by 1 pix_ce, clr_addr = previous rd_addr.
- obj_en=0 with all 32 slots in range -> zero wr_en pulses; clr_en pulses unchanged.
- OBJ_LIMIT_EN, MAX_PER_LINE=16, 20 in-range slots -> exactly 128 wr_en pulses, ovf=1; ovf clears on next line_start.
